// File: rtl/micro_seq_pkg.sv
// rtl/micro_seq_pkg.sv - sequencing codes, dispatch targets and dispatch table lookups
package micro_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_JUMP = 2'b00,
    SEQ_DISP = 2'b01,
    SEQ_CALL = 2'b10,
    SEQ_RET  = 2'b11
  } seq_ctl_t;

  localparam int unsigned DISP_MEMADR = 2;
  localparam int unsigned DISP_EXECR  = 6;
  localparam int unsigned DISP_EXECI  = 7;
  localparam int unsigned DISP_B      = 9;
  localparam int unsigned DISP_BL     = 10;
  localparam int unsigned MEM_LDR     = 3;
  localparam int unsigned MEM_STR     = 5;
  localparam int unsigned MEM_LDRB    = 11;

  localparam int unsigned DEF_ADDR_W    = 5;
  localparam int unsigned DEF_RESET_ADR = 0;

  // Table 0: top-level instruction decode on op, with funct refining branch/exec kinds
  function automatic int unsigned disp_decode(input logic [1:0] op, input logic [5:0] funct);
    if (op == 2'b01)
      return DISP_MEMADR;
    else if (op == 2'b10)
      return funct[4] ? DISP_BL : DISP_B;
    else
      return funct[5] ? DISP_EXECI : DISP_EXECR;
  endfunction

  // Table 1: memory access kind; funct[0] = load, funct[2] = byte
  function automatic int unsigned disp_mem(input logic [5:0] funct);
    if (funct[0])
      return funct[2] ? MEM_LDRB : MEM_LDR;
    else
      return MEM_STR;
  endfunction

endpackage

// File: rtl/micro_sequencer_if.sv
// rtl/micro_sequencer_if.sv - microinstruction sequencing fields in, micro-PC out
interface micro_sequencer_if #(
  parameter int ADDR_W = 5
);
  import micro_seq_pkg::*;

  seq_ctl_t          seq_ctl;
  logic [ADDR_W-1:0] next_adr;
  logic [1:0]        disp_sel;
  logic [1:0]        op;
  logic [5:0]        funct;
  logic [ADDR_W-1:0] upc;

  modport master (output seq_ctl, next_adr, disp_sel, op, funct, input upc);
  modport slave  (input seq_ctl, next_adr, disp_sel, op, funct, output upc);
endinterface

// File: rtl/micro_return_stack.sv
// rtl/micro_return_stack.sv - microsubroutine return-address stack; ignores push when full, pop when empty
module micro_return_stack #(
  parameter int ADDR_W      = 5,
  parameter int STACK_DEPTH = 4,
  localparam int DW         = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic [DW-1:0]     depth,
  output logic              full,
  output logic              empty
);

  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [DW-1:0] ONE = DW'(1);

  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic [DW-1:0]     top_ptr;

  assign full    = (depth == DW'(STACK_DEPTH));
  assign empty   = (depth == '0);
  assign top_ptr = depth - ONE;
  assign top     = mem[top_ptr[IW-1:0]];

  // Contents need no reset: depth alone defines which entries are valid
  always_ff @(posedge clk) begin
    if (push && !full && !clear)
      mem[depth[IW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      depth <= '0;
    else if (clear)
      depth <= '0;
    else if (push && !full)
      depth <= depth + ONE;
    else if (pop && !empty)
      depth <= depth - ONE;
  end

endmodule

// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - micro-PC sequencer with jump, dispatch, call/return, stall, restart
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter int                ADDR_W      = 5,
  parameter int                STACK_DEPTH = 4,
  parameter int                NUM_DISP    = 2,
  parameter logic [ADDR_W-1:0] RESET_ADR   = '0,
  parameter logic [ADDR_W-1:0] FAULT_ADR   = '1,
  localparam int               DW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  restart,
  input  logic                  stall,
  input  logic                  err_clr,
  micro_sequencer_if.slave      sif,
  output logic [DW-1:0]         depth,
  output logic                  stack_full,
  output logic                  stack_empty,
  output logic                  ovf,
  output logic                  unf
);

  logic [ADDR_W-1:0] upc_q;
  logic [ADDR_W-1:0] upc_nxt;
  logic [ADDR_W-1:0] disp_adr;
  logic [ADDR_W-1:0] stack_top;
  logic              push;
  logic              pop;
  logic              clr;
  logic              ovf_set;
  logic              unf_set;

  assign sif.upc = upc_q;

  // Only tables 0 and 1 exist; any other select lands on the fault handler
  always_comb begin
    disp_adr = FAULT_ADR;
    if (int'(sif.disp_sel) < NUM_DISP) begin
      case (sif.disp_sel)
        2'd0:    disp_adr = ADDR_W'(disp_decode(sif.op, sif.funct));
        2'd1:    disp_adr = ADDR_W'(disp_mem(sif.funct));
        default: disp_adr = FAULT_ADR;
      endcase
    end
  end

  always_comb begin
    upc_nxt = upc_q;
    push    = 1'b0;
    pop     = 1'b0;
    clr     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (restart) begin
      upc_nxt = RESET_ADR;
      clr     = 1'b1;
    end else if (!stall) begin
      case (sif.seq_ctl)
        SEQ_JUMP: upc_nxt = sif.next_adr;
        SEQ_DISP: upc_nxt = disp_adr;
        SEQ_CALL: begin
          if (stack_full) begin
            upc_nxt = FAULT_ADR;
            ovf_set = 1'b1;
          end else begin
            upc_nxt = sif.next_adr;
            push    = 1'b1;
          end
        end
        SEQ_RET: begin
          if (stack_empty) begin
            upc_nxt = FAULT_ADR;
            unf_set = 1'b1;
          end else begin
            upc_nxt = stack_top;
            pop     = 1'b1;
          end
        end
      endcase
    end
  end

  // A new fault outranks err_clr in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upc_q <= RESET_ADR;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      upc_q <= upc_nxt;
      ovf   <= ovf_set | (ovf & ~err_clr);
      unf   <= unf_set | (unf & ~err_clr);
    end
  end

  micro_return_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .clear     (clr),
    .push      (push),
    .pop       (pop),
    .push_data (upc_q + ADDR_W'(1)),
    .top       (stack_top),
    .depth     (depth),
    .full      (stack_full),
    .empty     (stack_empty)
  );

endmodule
